move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 124 ++++++++++++
 tb/tb_move_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Move sequencer: queues one-hot direction commands and walks each one through
// the move / spawn / game-over-check handshakes with the board datapath.
module move_sequencer #(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       move_req,
  output logic [1:0] move_dir,
  input  logic       move_done,
  input  logic       move_changed,
  output logic       spawn_req,
  input  logic       spawn_done,
  output logic       check_req,
  input  logic       check_done,
  input  logic       no_moves,
  output logic       busy,
  output logic       game_over,
  output logic       dropped
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_MOVE, WAIT_SPAWN, WAIT_CHECK, OVER} state_t;

  state_t        state, stateNxt;
  logic [1:0]    mem [QDEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;

  logic       btnValid, full, push, pop, drop;
  logic [1:0] btnDir;
  logic       moveReqNxt, spawnReqNxt, checkReqNxt;

  // A command is exactly one bit set; zero and multi-hot are noise.
  assign btnValid = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
  assign full     = (count == (AW+1)'(QDEPTH));

  // One-hot button to direction index.
  always_comb begin
    btnDir = 2'd0;
    case (btn)
      4'b0010: btnDir = 2'd1;
      4'b0100: btnDir = 2'd2;
      4'b1000: btnDir = 2'd3;
      default: btnDir = 2'd0;
    endcase
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = btnValid && (state != OVER) && (!full || pop);
  assign drop = btnValid && (state != OVER) && full && !pop;

  // Queue storage; stale entries are harmless, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= btnDir;
  end

  // Queue pointers and occupancy; game over flushes everything.
  always_ff @(posedge clk) begin
    if (rst || state == OVER) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // FSM next-state: each done input only matters in its own wait state.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:       if (count != '0)  stateNxt = WAIT_MOVE;
      WAIT_MOVE:  if (move_done)    stateNxt = move_changed ? WAIT_SPAWN : IDLE;
      WAIT_SPAWN: if (spawn_done)   stateNxt = WAIT_CHECK;
      WAIT_CHECK: if (check_done)   stateNxt = no_moves ? OVER : IDLE;
      OVER:                         stateNxt = OVER;
      default:                      stateNxt = IDLE;
    endcase
  end

  // FSM outputs: decide the requests that go out on the next cycle.
  always_comb begin
    pop         = (state == IDLE) && (count != '0);
    moveReqNxt  = pop;
    spawnReqNxt = (state == WAIT_MOVE) && move_done && move_changed;
    checkReqNxt = (state == WAIT_SPAWN) && spawn_done;
  end

  // Registered single-cycle pulses; move_dir is held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_req  <= 1'b0;
      spawn_req <= 1'b0;
      check_req <= 1'b0;
      dropped   <= 1'b0;
      move_dir  <= 2'd0;
    end else begin
      move_req  <= moveReqNxt;
      spawn_req <= spawnReqNxt;
      check_req <= checkReqNxt;
      dropped   <= drop;
      if (pop) move_dir <= mem[rdPtr];
    end
  end

  assign busy      = (state != IDLE) || (count != '0);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios followed by random traffic,
// all checked against a transaction-level model built on a queue.
module tb_move_sequencer;

  localparam int QD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       move_done, move_changed, spawn_done, check_done, no_moves;
  logic       move_req, spawn_req, check_req, busy, game_over, dropped;
  logic [1:0] move_dir;

  int errors = 0;
  int checks = 0;

  // Reference model: pending directions and the current handshake phase
  // (0 idle, 1 awaiting move, 2 awaiting spawn, 3 awaiting check, 4 game over).
  bit [1:0] mq[$];
  int       ph;
  bit       eMr, eSr, eCr, eDrop;
  bit [1:0] eDir;

  bit [1:0] issued[$];
  int       dropCnt;
  bit       lastMr;

  move_sequencer #(.QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .move_req(move_req), .move_dir(move_dir),
    .move_done(move_done), .move_changed(move_changed),
    .spawn_req(spawn_req), .spawn_done(spawn_done),
    .check_req(check_req), .check_done(check_done), .no_moves(no_moves),
    .busy(busy), .game_over(game_over), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic [3:0] b, input bit md, input bit mc, input bit sd,
                      input bit cd, input bit nm, input bit r);
    bit       valid;
    bit [1:0] d;
    bit       popped;
    @(negedge clk);
    btn = b; move_done = md; move_changed = mc; spawn_done = sd;
    check_done = cd; no_moves = nm; rst = r;
    @(posedge clk);
    valid = ($countones(b) == 1);
    d = 2'd0;
    for (int i = 0; i < 4; i++) if (b[i]) d = 2'(i);
    eMr = 0; eSr = 0; eCr = 0; eDrop = 0;
    if (r) begin
      mq.delete(); ph = 0; eDir = 2'd0;
    end else if (ph == 4) begin
      mq.delete();
    end else begin
      popped = 0;
      if (ph == 0 && mq.size() > 0) begin
        eDir = mq.pop_front(); eMr = 1; popped = 1;
      end
      if (valid) begin
        if (mq.size() >= QD) eDrop = 1;
        else mq.push_back(d);
      end
      if (popped) ph = 1;
      else if (ph == 1 && md) begin
        if (mc) begin ph = 2; eSr = 1; end else ph = 0;
      end else if (ph == 2 && sd) begin
        ph = 3; eCr = 1;
      end else if (ph == 3 && cd) begin
        ph = nm ? 4 : 0;
      end
    end
    #1;
    chk("move_req", move_req, eMr);
    chk("spawn_req", spawn_req, eSr);
    chk("check_req", check_req, eCr);
    chk("dropped", dropped, eDrop);
    chk("move_dir", move_dir, eDir);
    chk("game_over", game_over, ph == 4);
    chk("busy", busy, (ph != 0) || (mq.size() != 0));
    if (move_req) issued.push_back(move_dir);
    if (dropped) dropCnt++;
    lastMr = move_req;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ph = 0; eDir = 0; dropCnt = 0; lastMr = 0;
    btn = 0; move_done = 0; move_changed = 0; spawn_done = 0;
    check_done = 0; no_moves = 0; rst = 1;

    // Reset, with a btn pulse that must be discarded.
    step(4'b0001, 0, 0, 0, 0, 0, 1);
    chk("reset_busy", busy, 0);
    chk("reset_dir", move_dir, 0);
    idle(2);
    chk("reset_pulse_discarded", busy, 0);

    // Full transaction, left: move_req two cycles after the button.
    step(4'b0100, 0, 0, 0, 0, 0, 0);
    chk("lat_early", move_req, 0);
    step(4'd0, 0, 0, 0, 0, 0, 0);
    chk("lat_req", move_req, 1);
    chk("lat_dir", move_dir, 2);
    idle(2);
    step(4'd0, 1, 1, 0, 0, 0, 0);
    chk("spawn_after_done", spawn_req, 1);
    idle(1);
    step(4'd0, 0, 0, 1, 0, 0, 0);
    chk("check_after_spawn", check_req, 1);
    step(4'd0, 0, 0, 0, 1, 0, 0);
    chk("idle_busy", busy, 0);

    // Unchanged board: straight back to idle.
    step(4'b0001, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(4'd0, 1, 0, 0, 0, 0, 0);
    idle(3);
    chk("nochange_busy", busy, 0);

    // Noise on btn.
    step(4'b0011, 0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 0);
    chk("noise_busy", busy, 0);
    chk("noise_drop", dropped, 0);

    // Overflow while held in the move wait, then drain in order.
    dropCnt = 0;
    step(4'b1000, 0, 0, 0, 0, 0, 0);
    idle(1);
    issued.delete();
    step(4'b0001, 0, 0, 0, 0, 0, 0);
    step(4'b0010, 0, 0, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(4'd0, lastMr, 0, 0, 0, 0, 0);
    chk("drop_count", 4'(dropCnt), 1);
    chk("issued_count", 4'(issued.size()), 4);
    if (issued.size() == 4)
      for (int i = 0; i < 4; i++) chk("fifo_order", issued[i], 4'(i));

    // Game over: sticky, ignores buttons, cleared only by reset.
    step(4'b0001, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(4'd0, 1, 1, 0, 0, 0, 0);
    step(4'd0, 0, 0, 1, 0, 0, 0);
    step(4'd0, 0, 0, 0, 1, 1, 0);
    chk("game_over_set", game_over, 1);
    dropCnt = 0;
    for (int i = 0; i < 6; i++) step(4'b0010, 1, 1, 1, 1, 0, 0);
    chk("game_over_held", game_over, 1);
    chk("over_no_drop", 4'(dropCnt), 0);
    step(4'd0, 0, 0, 0, 0, 0, 1);
    chk("game_over_clear", game_over, 0);

    // Reset mid-spawn, late spawn_done ignored, then normal service.
    step(4'b0100, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(4'd0, 1, 1, 0, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0, 1);
    step(4'd0, 0, 0, 1, 0, 0, 0);
    chk("late_spawn_ignored", check_req, 0);
    issued.delete();
    step(4'b1000, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("after_reset_served", 4'(issued.size()), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int       sel;
      logic [3:0] b;
      sel = $urandom_range(0, 9);
      if (sel < 5)      b = 4'b0001 << $urandom_range(0, 3);
      else if (sel < 7) b = 4'd0;
      else              b = 4'($urandom_range(0, 15));
      step(b, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
